// File: rtl/picorisc_fetch_pkg.sv
// Shared types and constants for the picoRISC instruction-fetch stage.
// fetch_state_t is exported so the FSM state can be observed from outside the block.
package picorisc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } fetch_state_t;

  localparam int OPC_W = 6;

  // Must stay identical to `NOP in opcodes.svh.
  localparam logic [OPC_W-1:0] OPC_NOP = 6'b111111;

  // While no instruction is live, the decoder must see NOP instead of stale bits.
  function automatic logic [OPC_W-1:0] opcode_gate(input logic live,
                                                   input logic [OPC_W-1:0] field);
    return live ? field : OPC_NOP;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for the fetch stage.
// Priority is absolute branch, then relative branch, then increment.
module pc_next_calc #(
  parameter int PSIZE = 8
) (
  input  logic [PSIZE-1:0] pc,
  input  logic [PSIZE-1:0] field,
  input  logic             incr,
  input  logic             absbranch,
  input  logic             relbranch,
  output logic [PSIZE-1:0] next_pc,
  output logic             take
);

  logic [PSIZE-1:0] rel_target;
  logic [PSIZE-1:0] inc_target;

  // Adding a sign-extended PSIZE-bit offset and keeping PSIZE bits gives
  // the same result as a plain PSIZE-bit add, so no extension is needed.
  assign rel_target = pc + field;
  assign inc_target = pc + PSIZE'(1);

  assign take = incr | absbranch | relbranch;

  always_comb begin
    next_pc = pc;
    if (absbranch) begin
      next_pc = field;
    end else if (relbranch) begin
      next_pc = rel_target;
    end else if (incr) begin
      next_pc = inc_target;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// picoRISC fetch stage: holds the PC, fetches from program memory and
// presents the instruction to the decoder, counting retired instructions.
module pc_fetch
  import picorisc_fetch_pkg::*;
#(
  parameter int PSIZE = 8,
  parameter int ISIZE = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PSIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_rdata,
  input  logic             imem_valid,
  input  logic             pc_incr,
  input  logic             pc_absbranch,
  input  logic             pc_relbranch,
  output logic [ISIZE-1:0] instr,
  output logic             instr_valid,
  output logic [5:0]       opcode,
  output logic [PSIZE-1:0] pc,
  output logic [CNT_W-1:0] retired,
  output fetch_state_t     dbg_state
);

  // Handshake: imem_req is a one-cycle pulse with imem_addr; memory answers
  // with imem_valid/imem_rdata any later cycle, and only WAIT accepts it.
  // Downstream, instr_valid is the offer; any PC control high in ISSUE is
  // the decoder's acceptance, all low is a stall that freezes the stage.

  fetch_state_t     state_q, state_d;
  logic [PSIZE-1:0] pc_q;
  logic [ISIZE-1:0] instr_q;
  logic [CNT_W-1:0] retired_q;
  logic             capture;
  logic             advance;
  logic             take;
  logic [PSIZE-1:0] next_pc;
  logic             in_issue;

  assign in_issue = (state_q == ISSUE);

  pc_next_calc #(
    .PSIZE(PSIZE)
  ) u_next (
    .pc        (pc_q),
    .field     (instr_q[PSIZE-1:0]),
    .incr      (pc_incr),
    .absbranch (pc_absbranch),
    .relbranch (pc_relbranch),
    .next_pc   (next_pc),
    .take      (take)
  );

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    capture  = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (imem_valid) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (take) begin
          advance = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= {OPC_NOP, {(ISIZE-OPC_W){1'b0}}};
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        instr_q <= imem_rdata;
      end
      if (advance) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = in_issue;
  assign opcode      = opcode_gate(in_issue, instr_q[ISIZE-1 -: OPC_W]);
  assign retired     = retired_q;
  assign dbg_state   = state_q;

endmodule
